// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and ID/EX payload layout
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   localparam int CTRL_W   = 11;
   localparam int WR_W     = 5;
   localparam int EXT_W    = 16;
   localparam int WORD_W   = 32;

   localparam int CTRL_OFF = 0;
   localparam int WR_OFF   = CTRL_OFF + CTRL_W;
   localparam int EXT_OFF  = WR_OFF + WR_W;
   localparam int RD2_OFF  = EXT_OFF + EXT_W;
   localparam int RD1_OFF  = RD2_OFF + WORD_W;
   localparam int PC4_OFF  = RD1_OFF + WORD_W;
   localparam int PC_OFF   = PC4_OFF + WORD_W;
   localparam int IDEX_W   = PC_OFF + WORD_W;

   function automatic logic [IDEX_W-1:0] idex_pack(
      input logic [WORD_W-1:0] pc,
      input logic [WORD_W-1:0] pc4,
      input logic [WORD_W-1:0] rd1,
      input logic [WORD_W-1:0] rd2,
      input logic [EXT_W-1:0]  ext,
      input logic [WR_W-1:0]   wr,
      input logic [CTRL_W-1:0] ctrl
   );
      return {pc, pc4, rd1, rd2, ext, wr, ctrl};
   endfunction

   function automatic logic [WORD_W-1:0] idex_pc(input logic [IDEX_W-1:0] p);
      return p[PC_OFF +: WORD_W];
   endfunction

   function automatic logic [WR_W-1:0] idex_wr(input logic [IDEX_W-1:0] p);
      return p[WR_OFF +: WR_W];
   endfunction

   function automatic logic [CTRL_W-1:0] idex_ctrl(input logic [IDEX_W-1:0] p);
      return p[CTRL_OFF +: CTRL_W];
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - valid/ready pipeline stage with optional skid entry
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = 160,
   parameter int SKID   = 1,
   parameter int CNT_W  = 32
) (
   input  logic              cpu_clk,
   input  logic              cpu_rstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occ,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   localparam logic USE_SKID = (SKID != 0);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_in_ready;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;

   logic w_in_ready;
   logic w_out_valid;
   logic w_in_fire;
   logic w_out_fire;
   logic w_load_main;
   logic w_load_skid;
   logic w_main_from_skid;
   logic w_stall_inc;

   assign w_out_valid = (r_state != ST_EMPTY);
   // Skid build takes in_ready from a flop so upstream never sees out_ready.
   assign w_in_ready  = USE_SKID ? r_in_ready : (!w_out_valid || out_ready);
   assign w_in_fire   = in_valid && w_in_ready;
   assign w_out_fire  = w_out_valid && out_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main      = 1'b0;
      w_load_skid      = 1'b0;
      w_main_from_skid = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_load_main = 1'b1;
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (w_in_fire && w_out_fire) begin
               w_load_main = 1'b1;
            end else if (w_in_fire && USE_SKID) begin
               w_load_skid = 1'b1;
               w_state_nxt = ST_SKID;
            end else if (w_out_fire) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (w_out_fire) begin
               w_load_main      = 1'b1;
               w_main_from_skid = 1'b1;
               w_state_nxt      = ST_FULL;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      // Handshakes still complete under flush, but nothing is retained.
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_load_main = 1'b0;
         w_load_skid = 1'b0;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_SKID);
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main) begin
            r_main <= w_main_from_skid ? r_skid : in_data;
         end
         if (w_load_skid) begin
            r_skid <= in_data;
         end
      end
   end

   assign w_stall_inc = w_out_valid && !out_ready;

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk   (cpu_clk),
      .rst_n (cpu_rstn),
      .inc   (w_stall_inc),
      .clr   (stall_clr),
      .count (stall_cnt)
   );

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = r_main;
   assign occ       = r_state;

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register that generalises the per-field ID/EX latch into one flat payload bus. It uses a valid/ready handshake instead of a global suspend, so back-pressure propagates stage by stage. An optional 2-entry skid buffer keeps in_ready fully registered, which breaks the ready timing path. It also provides a synchronous flush for branch redirects and a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_W, 160, payload width in bits (concatenated pc, pc4, rD1, rD2, ext, wR and control fields).
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
CNT_W, 32, width of the stall-cycle counter.

Ports:
cpu_clk  in  1  clock, rising edge.
cpu_rstn  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of all held entries.
in_valid  in  1  upstream holds a valid payload.
in_ready  out  1  stage can accept this cycle.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  main register holds a valid payload.
out_ready  in  1  downstream accepts this cycle.
out_data  out  DATA_W  main register contents.
occ  out  2  entries held (0..2; max 1 when SKID=0).
stall_cnt  out  CNT_W  saturating count of cycles with out_valid && !out_ready.
stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- in_fire = in_valid && in_ready. out_fire = out_valid && out_ready.
- Reset (cpu_rstn=0, async):
  - state EMPTY, out_valid=0, occ=0, stall_cnt=0.
  - main and skid data = 0.
  - in_ready=1 after reset releases.
- SKID=1 state machine. States are EMPTY, FULL and SKID. out_valid = (state != EMPTY). in_ready = (state != SKID), driven straight from a flop.
  - EMPTY: in_fire -> main <= in_data, go to FULL.
  - FULL, in_fire && out_fire: main <= in_data, stay in FULL.
  - FULL, in_fire only: skid <= in_data, go to SKID.
  - FULL, out_fire only: go to EMPTY.
  - FULL, neither: hold.
  - SKID: in_ready=0. out_fire -> main <= skid, go to FULL. Otherwise hold.
- SKID=0: no SKID state.
  - in_ready = !out_valid || out_ready (combinational).
  - in_fire loads main and sets out_valid=1.
  - out_fire without in_fire clears out_valid.
- Latency: a payload accepted in cycle N appears on out_data/out_valid in cycle N+1. A skid-buffered payload appears one cycle after the blocking out_fire.
- Order is strictly FIFO. No payload is dropped or duplicated except by flush.
- flush has the highest priority:
  - next state is EMPTY and occ=0.
  - An in_fire or out_fire in the same cycle still completes as a handshake, but the incoming payload is discarded.
  - Data registers are don't-care after flush; the implementation may leave them unchanged.
- occ reports the registered state: EMPTY=0, FULL=1, SKID=2.
- stall_cnt:
  - Increments by 1 each cycle out_valid && !out_ready.
  - Saturates at all-ones; there is no wrap-around.
  - stall_clr takes priority over increment and clears to 0 on the next edge.
  - flush does not clear stall_cnt.
- out_data is stable whenever out_valid && !out_ready (AXI-style hold). in_data/in_valid are not required to be stable from upstream.

Decomposition:
- Shared package pipe_pkg holds:
  - the state encoding localparams: ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
  - the ID/EX payload field offsets/widths, so producer and consumer pack and unpack identically.
- One sub-module is natural: sat_counter (parameter width; inputs inc and clr; output count) for stall_cnt. It is reusable by other stages.

Test Plan:
- Reset then stream: hold out_ready=1 and drive in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each, with in_ready=1 and occ=1 throughout, and stall_cnt=0.
- Backpressure/skid (SKID=1): accept A=0xA, drop out_ready, offer B=0xB.
  - B is accepted and occ=2; in_ready=0 next cycle; C=0xC is held upstream.
  - Raise out_ready -> outputs A, B, C in order with no loss or duplicate.
- Flush mid-SKID: fill to occ=2, then pulse flush with in_valid=1 and in_data=0xD -> next cycle out_valid=0, occ=0, in_ready=1, and 0xD never appears.
- Stall counter: out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5. Then stall_clr for 1 cycle -> 0. With CNT_W=3, 10 stalled cycles -> stall_cnt=7 and it stays there.
- SKID=0 build: out_ready=0 with the register full -> in_ready=0 in the same cycle. out_ready=1 and in_valid=1 in the same cycle -> simultaneous replace, out_valid stays 1, occ=1.
- Async reset mid-operation: assert cpu_rstn=0 off the clock edge while occ=2 -> out_valid=0, occ=0, stall_cnt=0 immediately, without waiting for the next cpu_clk edge. After release the first accepted payload streams normally.
